lane_rr_scheduler: RTL and testbench

- Single-clock round-robin burst scheduler that merges four 8-bit valid/ready requester lanes onto one registered output stream.
- Replaces the multi-clock 2:1 mux tree in the PHY transmit path when all lanes share one clock domain.
- Grants one lane at a time for a burst of up to BURST_LEN beats, then rotates priority.
- Tags each output beat with its source lane so the receive side can demultiplex.

---
 rtl/lane_rr_scheduler.sv | 119 +++++++++++
 tb/tb_lane_rr_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_rr_scheduler.sv
// Four-lane round-robin burst scheduler with a registered, lane-tagged output stage.
// Optional per-lane saturating beat counters on beat_cnt_bus are enabled by defining SCHED_STATS_EN.
module lane_rr_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic [3:0]              in_valid,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  output logic [3:0]              in_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [1:0]              out_lane,
  input  logic                    out_ready,
  output logic                    busy
`ifdef SCHED_STATS_EN
  ,
  output logic [4*CNT_WIDTH-1:0]  beat_cnt_bus
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  if (BURST_LEN < 1 || BURST_LEN > 15 || CNT_WIDTH < 1) begin : g_bad_param
    $error("lane_rr_scheduler: BURST_LEN must be 1..15 and CNT_WIDTH >= 1");
  end

  logic [0:0]            state;
  logic [1:0]            rr_ptr;
  logic [1:0]            grant;
  logic [3:0]            beat_idx;
  logic                  load_en;
  logic                  xfer;
  logic                  last_beat;
  logic [DATA_WIDTH-1:0] lane_data;

  // First requesting lane at or after ptr, wrapping modulo 4.
  function automatic logic [1:0] pick_lane(input logic [3:0] v, input logic [1:0] ptr);
    logic [1:0] idx;
    pick_lane = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (v[idx]) pick_lane = idx;
    end
  endfunction

  assign load_en   = !out_valid || out_ready;
  assign xfer      = (state == BURST) && load_en && in_valid[grant];
  assign last_beat = (beat_idx == 4'(BURST_LEN - 1));
  assign lane_data = in_data[grant*DATA_WIDTH +: DATA_WIDTH];
  assign in_ready  = ((state == BURST) && load_en) ? (4'b0001 << grant) : 4'b0000;
  assign busy      = (state == BURST);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= IDLE;
      rr_ptr   <= 2'd0;
      grant    <= 2'd0;
      beat_idx <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|in_valid) begin
            grant    <= pick_lane(in_valid, rr_ptr);
            beat_idx <= 4'd0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            if (last_beat) begin
              state  <= IDLE;
              rr_ptr <= grant + 2'd1;
            end else begin
              beat_idx <= beat_idx + 4'd1;
            end
          end else if (!in_valid[grant]) begin
            // Lane dropped mid-burst: forfeit the rest of its slot.
            state  <= IDLE;
            rr_ptr <= grant + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= 2'd0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= lane_data;
      out_lane  <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SCHED_STATS_EN
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt;
    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        cnt <= '0;
      end else if (xfer && (grant == 2'(i)) && !(&cnt)) begin
        cnt <= cnt + 1'b1;
      end
    end
    assign beat_cnt_bus[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end
`endif

endmodule

// File: tb/tb_lane_rr_scheduler.sv
// Bench for lane_rr_scheduler: directed scenarios plus randomized traffic against a transaction-level model.
module tb_lane_rr_scheduler;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_L;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_lane;
  logic          out_ready;
  logic          busy;
  logic [3:0]    s_in_ready;
  logic          s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_out_lane;
  logic          s_busy;
`ifdef SCHED_STATS_EN
  logic [4*CW-1:0] beat_cnt_bus;
  logic [4*CW-1:0] s_beat_cnt_bus;
`endif

  int checks = 0;
  int failures = 0;

  lane_rr_scheduler #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_lane(out_lane), .out_ready(out_ready), .busy(busy)
`ifdef SCHED_STATS_EN
    , .beat_cnt_bus(beat_cnt_bus)
`endif
  );

  lane_rr_scheduler #(.DATA_WIDTH(DW), .BURST_LEN(1), .CNT_WIDTH(CW)) dut_single (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_lane(s_out_lane), .out_ready(out_ready), .busy(s_busy)
`ifdef SCHED_STATS_EN
    , .beat_cnt_bus(s_beat_cnt_bus)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a grant is "a lane owning up to BL remaining beats".
  bit         m_busy;
  int         m_lane, m_left, m_ptr, m_ol;
  bit         m_ov;
  logic [7:0] m_od;
  int         m_cnt [4];

  task automatic model_reset();
    m_busy = 0; m_lane = 0; m_left = 0; m_ptr = 0;
    m_ov = 0; m_od = 8'h00; m_ol = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    r = 4'b0000;
    if (m_busy && (!m_ov || out_ready)) r[m_lane] = 1'b1;
    return r;
  endfunction

  task automatic model_tick();
    bit moved;
    bit can_take;
    moved = 0;
    can_take = !m_ov || out_ready;
    if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        if (!m_busy && in_valid[(m_ptr + k) % 4]) begin
          m_lane = (m_ptr + k) % 4;
          m_left = BL;
          m_busy = 1;
        end
      end
    end else if (in_valid[m_lane] && can_take) begin
      moved = 1;
      m_od = in_data[m_lane*DW +: DW];
      m_ol = m_lane;
      if (m_cnt[m_lane] < (1 << CW) - 1) m_cnt[m_lane]++;
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_ptr = (m_lane + 1) % 4;
      end
    end else if (!in_valid[m_lane]) begin
      m_busy = 0;
      m_ptr = (m_lane + 1) % 4;
    end
    if (moved) m_ov = 1;
    else if (out_ready) m_ov = 0;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    in_valid = 4'b0000;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    in_valid = 4'hF;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, busy, out_lane, out_data} !== 16'h0) begin
      failures++;
      $display("FAIL reset_hold: got ov=%b rdy=%b busy=%b lane=%0d data=%h, want all 0",
               out_valid, in_ready, busy, out_lane, out_data);
    end
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 4'b0001 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant: got rdy=%b busy=%b, want 0001/1", in_ready, busy);
    end
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_lane !== 2'd1) begin
      failures++;
      $display("FAIL reset_pre_async: got ov=%b lane=%0d, want 1/1", out_valid, out_lane);
    end
    #2 reset_L = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, busy, out_lane} !== 8'h0) begin
      failures++;
      $display("FAIL reset_async: got ov=%b rdy=%b busy=%b lane=%0d, want all 0",
               out_valid, in_ready, busy, out_lane);
    end
  endtask

  task automatic test_round_robin();
    int p, lane;
    do_reset();
    in_valid = 4'hF;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      @(posedge clk); #1;
      if (n >= 2) begin
        p = (n - 2) % 5;
        lane = ((n - 2) / 5) % 4;
        checks++;
        if (p == 4) begin
          if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_bubble edge %0d: got ov=%b, want 0", n, out_valid);
          end
        end else if (out_valid !== 1'b1 || out_lane !== 2'(lane) || out_data !== 8'(8'hA0 + lane)) begin
          failures++;
          $display("FAIL rr_beat edge %0d: got ov=%b lane=%0d data=%h, want 1/%0d/%h",
                   n, out_valid, out_lane, out_data, lane, 8'hA0 + lane);
        end
      end
    end
  endtask

  task automatic test_short_burst();
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b0100;
    in_data[23:16] = 8'h11;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL short_grant: got rdy=%b, want 0100", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || out_lane !== 2'd2) begin
      failures++;
      $display("FAIL short_beat0: got ov=%b data=%h lane=%0d, want 1/11/2", out_valid, out_data, out_lane);
    end
    @(negedge clk);
    in_data[23:16] = 8'h22;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22 || out_lane !== 2'd2) begin
      failures++;
      $display("FAIL short_beat1: got ov=%b data=%h lane=%0d, want 1/22/2", out_valid, out_data, out_lane);
    end
    @(negedge clk);
    in_valid = 4'b1001;
    in_data = {8'h33, 8'h00, 8'h00, 8'h44};
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL short_idle: got busy=%b ov=%b, want 0/0", busy, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++;
      $display("FAIL short_next_grant: got rdy=%b, want 1000", in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got [$];
    int src_i, stall_left;
    bit seen, fire;
    do_reset();
    src_i = 0; stall_left = 0; seen = 0;
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      in_valid = (src_i < 4) ? 4'b0010 : 4'b0000;
      in_data[15:8] = 8'(src_i + 1);
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        checks++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h01) begin
          failures++;
          $display("FAIL bp_hold: got rdy=%b ov=%b data=%h, want 0000/1/01", in_ready, out_valid, out_data);
        end
      end
      fire = in_valid[1] && in_ready[1];
      if (out_valid && out_ready) got.push_back(out_data);
      @(posedge clk); #1;
      if (fire) src_i++;
      if (stall_left > 0) stall_left--;
      else if (!seen && out_valid) begin
        seen = 1;
        stall_left = 5;
      end
      @(negedge clk);
    end
    checks++;
    if (got.size() != 4) begin
      failures++;
      $display("FAIL bp_count: got %0d beats, want 4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++;
      if (got[i] !== 8'(i + 1)) begin
        failures++;
        $display("FAIL bp_order beat %0d: got %h, want %h", i, got[i], i + 1);
      end
    end
  endtask

  task automatic test_sparse();
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b1000;
    in_data[31:24] = 8'h5C;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (n >= 2) begin
        checks++;
        if (s_out_valid !== 1'((n % 2) == 0) || (s_out_valid && (s_out_lane !== 2'd3 || s_out_data !== 8'h5C))) begin
          failures++;
          $display("FAIL sparse edge %0d: got ov=%b lane=%0d data=%h, want ov=%b lane 3 data 5c",
                   n, s_out_valid, s_out_lane, s_out_data, (n % 2) == 0);
        end
      end
    end
  endtask

`ifdef SCHED_STATS_EN
  task automatic test_stats();
    int xfers;
    bit fire;
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b0001;
    in_data[7:0] = 8'h77;
    xfers = 0;
    for (int cyc = 0; cyc < 60 && xfers < 20; cyc++) begin
      #1;
      fire = in_valid[0] && in_ready[0];
      @(posedge clk); #1;
      if (fire) begin
        xfers++;
        if (xfers == 14) begin
          checks++;
          if (beat_cnt_bus[CW-1:0] !== 4'd14) begin
            failures++;
            $display("FAIL stats_mid: got %0d, want 14", beat_cnt_bus[CW-1:0]);
          end
        end
      end
      @(negedge clk);
    end
    in_valid = 4'b0000;
    checks++;
    if (xfers != 20) begin
      failures++;
      $display("FAIL stats_xfers: got %0d transfers, want 20", xfers);
    end
    checks++;
    if (beat_cnt_bus !== 16'h000F) begin
      failures++;
      $display("FAIL stats_sat: got bus=%h, want 000f", beat_cnt_bus);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] exp_rdy;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int l = 0; l < 4; l++) if ($urandom_range(0, 3) == 0) in_valid[l] = ~in_valid[l];
      in_data = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = model_ready();
      checks++;
      if (in_ready !== exp_rdy || busy !== m_busy) begin
        failures++;
        $display("FAIL rand_ready cyc %0d: got rdy=%b busy=%b, want %b/%b", cyc, in_ready, busy, exp_rdy, m_busy);
      end
      @(posedge clk);
      model_tick();
      #1;
      checks++;
      if (out_valid !== m_ov || (m_ov && (out_data !== m_od || out_lane !== 2'(m_ol)))) begin
        failures++;
        $display("FAIL rand_out cyc %0d: got ov=%b data=%h lane=%0d, want %b/%h/%0d",
                 cyc, out_valid, out_data, out_lane, m_ov, m_od, m_ol);
      end
`ifdef SCHED_STATS_EN
      for (int l = 0; l < 4; l++) begin
        checks++;
        if (beat_cnt_bus[l*CW +: CW] !== CW'(m_cnt[l])) begin
          failures++;
          $display("FAIL rand_cnt lane %0d cyc %0d: got %0d, want %0d", l, cyc, beat_cnt_bus[l*CW +: CW], m_cnt[l]);
        end
      end
`endif
      @(negedge clk);
    end
  endtask

  initial begin
    reset_L = 1'b0;
    in_valid = 4'b0000;
    in_data = '0;
    out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_short_burst();
    test_backpressure();
    test_sparse();
`ifdef SCHED_STATS_EN
    test_stats();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
